// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous single-port RAM
// between MASTER_CNT bus masters (instruction fetch, data, debug/DMA, ...).
//
// Grants are combinational from req and the last-granted pointer. Each accepted
// read is tagged with its master index so the RAM's one-cycle read data can be
// steered back as a one-hot rvalid strobe. Writes produce no response.
//
// Optional feature macro: MEM_ARBITER_REG_OUT_EN
//   defined   -> rdata/rvalid pass through one extra register stage (read latency 2)
//   undefined -> rdata/rvalid come straight from the tag register (read latency 1)
module mem_arbiter #(
    parameter int unsigned MASTER_CNT = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [MASTER_CNT-1:0]            req,
    input  logic [MASTER_CNT-1:0]            we,
    input  logic [MASTER_CNT*ADDR_WIDTH-1:0] addr,
    input  logic [MASTER_CNT*DATA_WIDTH-1:0] wdata,
    input  logic [MASTER_CNT*MASK_WIDTH-1:0] mask,
    output logic [MASTER_CNT-1:0]            gnt,
    output logic [MASTER_CNT-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [ADDR_WIDTH-1:0]            memAddr,
    output logic [DATA_WIDTH-1:0]            memWriteData,
    output logic [MASK_WIDTH-1:0]            memMask,
    output logic                             memWr,
    input  logic [DATA_WIDTH-1:0]            memReadData
);

    localparam int unsigned IDX_W = (MASTER_CNT > 1) ? $clog2(MASTER_CNT) : 1;

    // Unpacked views of the flattened master buses
    logic [ADDR_WIDTH-1:0] addrArr  [MASTER_CNT];
    logic [DATA_WIDTH-1:0] wdataArr [MASTER_CNT];
    logic [MASK_WIDTH-1:0] maskArr  [MASTER_CNT];

    for (genvar i = 0; i < MASTER_CNT; i++) begin : gUnpack
        assign addrArr[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdataArr[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign maskArr[i]  = mask[i*MASK_WIDTH +: MASK_WIDTH];
    end

    // Arbitration state and read-response tag
    logic [IDX_W-1:0]      lastQ;
    logic                  respValidQ;
    logic [IDX_W-1:0]      respTagQ;

    // Arbitration results
    logic [MASTER_CNT-1:0] hiMask;
    logic [MASTER_CNT-1:0] reqHi;
    logic                  anyGnt;
    logic [IDX_W-1:0]      gntIdx;
    logic [IDX_W-1:0]      selIdx;
    logic                  readAccept;

    // Response before the optional output stage
    logic [MASTER_CNT-1:0] rvalidNow;
    logic [DATA_WIDTH-1:0] rdataNow;

    // Masked round-robin: lowest requester above lastQ wins, else lowest requester overall
    always_comb begin
        hiMask = '0;
        for (int i = 0; i < MASTER_CNT; i++) begin
            hiMask[i] = (IDX_W'(i) > lastQ);
        end
        reqHi  = req & hiMask;
        anyGnt = 1'b0;
        gntIdx = '0;
        for (int i = MASTER_CNT - 1; i >= 0; i--) begin
            if (req[i]) begin
                anyGnt = 1'b1;
                gntIdx = IDX_W'(i);
            end
        end
        for (int i = MASTER_CNT - 1; i >= 0; i--) begin
            if (reqHi[i]) begin
                gntIdx = IDX_W'(i);
            end
        end
        // No grant may escape while reset is held, even though req may be high
        if (!reset) begin
            anyGnt = 1'b0;
        end
    end

    // One-hot grant and memory-side mux; idle cycles keep the last master selected
    always_comb begin
        gnt = '0;
        if (anyGnt) begin
            gnt[gntIdx] = 1'b1;
        end
        selIdx       = anyGnt ? gntIdx : lastQ;
        memAddr      = addrArr[selIdx];
        memWriteData = wdataArr[selIdx];
        memMask      = maskArr[selIdx];
        memWr        = anyGnt & we[gntIdx];
        readAccept   = anyGnt & ~we[gntIdx];
    end

    // Priority pointer and read tag; reset makes master 0 the first winner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastQ      <= IDX_W'(MASTER_CNT - 1);
            respValidQ <= 1'b0;
            respTagQ   <= '0;
        end else begin
            respValidQ <= readAccept;
            if (anyGnt) begin
                lastQ    <= gntIdx;
                respTagQ <= gntIdx;
            end
        end
    end

    // Steer RAM read data to the tagged master; rdata is zero when nothing is valid
    always_comb begin
        rvalidNow = '0;
        rdataNow  = '0;
        if (respValidQ) begin
            rvalidNow[respTagQ] = 1'b1;
            rdataNow            = memReadData;
        end
    end

`ifdef MEM_ARBITER_REG_OUT_EN
    logic [MASTER_CNT-1:0] rvalidQ;
    logic [DATA_WIDTH-1:0] rdataQ;

    // Extra output stage: adds one cycle of latency, keeps one response per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalidQ <= '0;
            rdataQ  <= '0;
        end else begin
            rvalidQ <= rvalidNow;
            rdataQ  <= rdataNow;
        end
    end

    assign rvalid = rvalidQ;
    assign rdata  = rdataQ;
`else
    assign rvalid = rvalidNow;
    assign rdata  = rdataNow;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with four masters.
// A reference model at each negedge derives the expected grant from the round-robin
// rule and queues expected read responses; a separate monitor pops and compares them.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
`ifdef MEM_ARBITER_REG_OUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req, we, gnt, rvalid;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N*MW-1:0]   mask;
    logic [DW-1:0]     rdata, memWriteData, memReadData;
    logic [AW-1:0]     memAddr;
    logic [MW-1:0]     memMask;
    logic              memWr;

    int     nCmp = 0;
    int     nFail = 0;
    longint cyc = 0;

    logic [DW-1:0] ram [64];
    logic [DW-1:0] modelMem [64];
    int            modelLast = N - 1;

    typedef struct {
        int            tag;
        logic [DW-1:0] data;
        longint        due;
    } exp_t;
    exp_t expQ[$];
    exp_t mon;

    mem_arbiter #(
        .MASTER_CNT(N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .mask        (mask),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .memAddr     (memAddr),
        .memWriteData(memWriteData),
        .memMask     (memMask),
        .memWr       (memWr),
        .memReadData (memReadData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM, read data one cycle after address
    always @(posedge clk) begin
        if (memWr) begin
            for (int b = 0; b < MW; b++) begin
                if (memMask[b]) ram[memAddr[7:2]][8*b +: 8] <= memWriteData[8*b +: 8];
            end
        end
        memReadData <= ram[memAddr[7:2]];
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
        nCmp++;
        if (act !== expv) begin
            nFail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, expv);
        end
    endfunction

    // Reference model: expected grant, memory side and queued read responses
    always @(negedge clk) begin
        int           g;
        int           j;
        int           idx;
        logic [N-1:0] expG;
        if (!reset) begin
            modelLast = N - 1;
            expQ.delete();
        end else begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                j = (modelLast + k) % N;
                if (g < 0 && req[j]) g = j;
            end
            expG = '0;
            if (g >= 0) expG[g] = 1'b1;
            check("gnt", gnt, expG);
            if (g < 0) begin
                check("memWr_idle", memWr, 0);
            end else begin
                check("memWr", memWr, we[g]);
                check("memAddr", memAddr, addr[g*AW +: AW]);
                idx = int'(addr[g*AW+2 +: 6]);
                if (we[g]) begin
                    check("memWriteData", memWriteData, wdata[g*DW +: DW]);
                    check("memMask", memMask, mask[g*MW +: MW]);
                    for (int b = 0; b < MW; b++) begin
                        if (mask[g*MW+b]) modelMem[idx][8*b +: 8] = wdata[g*DW+8*b +: 8];
                    end
                end else begin
                    expQ.push_back('{g, modelMem[idx], cyc + LAT});
                end
                modelLast = g;
            end
        end
    end

    // Monitor: every response strobe must match the oldest expected response
    always @(negedge clk) begin
        logic [N-1:0] expV;
        if (!reset) begin
            check("rvalid_in_reset", rvalid, 0);
        end else if (rvalid != '0) begin
            if (expQ.size() == 0) begin
                check("rvalid_spurious", rvalid, 0);
            end else begin
                mon  = expQ.pop_front();
                expV = '0;
                expV[mon.tag] = 1'b1;
                check("rvalid", rvalid, expV);
                check("rdata", rdata, mon.data);
                check("rlatency", cyc, mon.due);
            end
        end else if (expQ.size() != 0 && expQ[0].due <= cyc) begin
            mon  = expQ.pop_front();
            expV = '0;
            expV[mon.tag] = 1'b1;
            check("rvalid_missing", rvalid, expV);
        end
    end

    task automatic issue(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        req[i]             = 1'b1;
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
        mask[i*MW +: MW]   = m;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitGrant(int i);
        bit got = 1'b0;
        for (int c = 0; c < 4 * N && !got; c++) begin
            @(negedge clk);
            if (gnt[i]) got = 1'b1;
            else nextCycle();
        end
        if (!got) check("grant_timeout", gnt[i], 1);
        nextCycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] gs;
        int           cnt [N];
        for (int i = 0; i < 64; i++) ram[i] = (32'(i) * 32'h01010101) ^ 32'h5A000000;
        ram[4] = 32'hAAAA0000;
        ram[8] = 32'hBBBB0000;
        for (int i = 0; i < 64; i++) modelMem[i] = ram[i];
        reset = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0; mask = '0;

        // Reset held with all masters requesting
        for (int i = 0; i < N; i++) issue(i, 1'b0, 32'h10, '0, '0);
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", gnt, 0);
            check("rst_memWr", memWr, 0);
            check("rst_rvalid", rvalid, 0);
            check("rst_rdata", rdata, 0);
        end
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        check("first_gnt", gnt, 4'b0001);
        nextCycle();
        req = '0;
        repeat (3) nextCycle();

        // Contention: masters 0 and 1 read continuously
        issue(0, 1'b0, 32'h10, '0, '0);
        issue(1, 1'b0, 32'h20, '0, '0);
        repeat (10) nextCycle();
        req = '0;
        repeat (3) nextCycle();

        // Write / masked write / readback on master 1
        issue(1, 1'b1, 32'h40, 32'h11223344, 4'b1111);
        waitGrant(1);
        issue(1, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011);
        waitGrant(1);
        issue(1, 1'b0, 32'h40, '0, '0);
        waitGrant(1);
        req = '0;
        repeat (LAT - 1) nextCycle();
        check("readback_rvalid", rvalid, 4'b0010);
        check("readback_rdata", rdata, 32'h1122BEEF);
        repeat (3) nextCycle();

        // Read accepted, then reset pulsed before its response
        issue(0, 1'b0, 32'h10, '0, '0);
        waitGrant(0);
        req   = '0;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", rvalid, 0);
        nextCycle();
        reset = 1'b1;
        repeat (4) nextCycle();

        // Fairness after reset: all four request, order 0,1,2,3,0,1,2,3
        for (int i = 0; i < N; i++) begin
            issue(i, 1'b0, 32'(i * 16), '0, '0);
            cnt[i] = 0;
        end
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge clk);
            check("fair_order", gnt, 4'b0001 << (c % N));
            for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
            nextCycle();
        end
        for (int i = 0; i < N; i++) check("fair_count", 64'(cnt[i]), 2);
        req = '0;
        repeat (3) nextCycle();

        // Randomized traffic with holding, re-issue and withdrawal
        repeat (1500) begin
            @(negedge clk);
            gs = gnt;
            nextCycle();
            for (int i = 0; i < N; i++) begin
                if (gs[i] || !req[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        issue(i, 1'($urandom_range(0, 2) == 0), 32'($urandom_range(0, 63) * 4),
                              $urandom, 4'($urandom_range(0, 15)));
                    else
                        req[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        repeat (6) nextCycle();
        check("drain", 64'(expQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
